// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
//   state_t    : timer FSM encoding
//   bcd_time_t : packed mm:ss value, tens digits 3 bits, units digits 4 bits
//   clamp_*    : saturate a preset digit to its legal BCD maximum
package timer_pkg;

  localparam int UNITS_W   = 4;
  localparam int TENS_W    = 3;
  localparam int UNITS_MAX = 9;
  localparam int TENS_MAX  = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  typedef struct packed {
    logic [TENS_W-1:0]  mt;
    logic [UNITS_W-1:0] mu;
    logic [TENS_W-1:0]  st;
    logic [UNITS_W-1:0] su;
  } bcd_time_t;

  function automatic logic [UNITS_W-1:0] clamp_units(input logic [UNITS_W-1:0] d);
    return (d > UNITS_W'(UNITS_MAX)) ? UNITS_W'(UNITS_MAX) : d;
  endfunction

  function automatic logic [TENS_W-1:0] clamp_tens(input logic [TENS_W-1:0] d);
    return (d > TENS_W'(TENS_MAX)) ? TENS_W'(TENS_MAX) : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with borrow chaining.
//   clk, reset     : clock, async active-low reset (q -> 0)
//   load, ld_val   : synchronous preset, takes priority over borrow_in
//   borrow_in      : decrement request from the less significant digit
//   q              : current digit value
//   borrow_out     : this digit wraps 0 -> MAX on this decrement
module bcd_down_digit #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         borrow_in,
  output logic [W-1:0] q,
  output logic         borrow_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         q <= '0;
    else if (load)      q <= ld_val;
    else if (borrow_in) q <= (q == '0) ? W'(MAX) : q - W'(1);
  end

  assign borrow_out = borrow_in & (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with load/start/pause control.
//   clk, reset           : clock, async active-low reset
//   tick                 : count-enable strobe, one decrement per tick in RUN
//   load, ld_*           : preset mm:ss (clamped per digit), forces IDLE
//   start, pause         : run control, pause wins when both asserted
//   min_*, sec_*         : current BCD count (registered)
//   running              : registered state==RUN
//   done                 : one-clk pulse when the count reaches 00:00
// AUTO_RELOAD=1 reloads the last preset at terminal count and keeps running.
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [TENS_W-1:0]  ld_min_tens,
  input  logic [UNITS_W-1:0] ld_min_units,
  input  logic [TENS_W-1:0]  ld_sec_tens,
  input  logic [UNITS_W-1:0] ld_sec_units,
  input  logic               start,
  input  logic               pause,
  output logic [TENS_W-1:0]  min_tens,
  output logic [UNITS_W-1:0] min_units,
  output logic [TENS_W-1:0]  sec_tens,
  output logic [UNITS_W-1:0] sec_units,
  output logic               running,
  output logic               done
);

  state_t    r_state, w_nxt;
  bcd_time_t r_rld;
  logic      r_running, r_done;

  bcd_time_t w_clamp, w_dval, w_q;
  logic      w_dec, w_nz, w_term, w_reload, w_done_nxt, w_dload;
  logic [4:0] w_b;

  assign w_clamp = {clamp_tens(ld_min_tens), clamp_units(ld_min_units),
                    clamp_tens(ld_sec_tens), clamp_units(ld_sec_units)};

  // Pause and load both suppress the decrement on the edge they are sampled.
  assign w_dec  = (r_state == S_RUN) & tick & ~pause & ~load;
  assign w_nz   = (w_q != '0);
  assign w_term = (w_q == bcd_time_t'(1));
  assign w_b[0] = w_dec;

  // w_b[4] flags a decrement from 00:00. RUN never holds 00:00, but if it
  // ever did, the digits are forced back to 00:00 instead of wrapping to 59:59.
  assign w_dload = load | w_reload | w_b[4];
  assign w_dval  = load ? w_clamp : (w_reload ? r_rld : '0);

  bcd_down_digit #(.MAX(UNITS_MAX), .W(UNITS_W)) u_su (
    .clk(clk), .reset(reset), .load(w_dload), .ld_val(w_dval.su),
    .borrow_in(w_b[0]), .q(w_q.su), .borrow_out(w_b[1]));
  bcd_down_digit #(.MAX(TENS_MAX), .W(TENS_W)) u_st (
    .clk(clk), .reset(reset), .load(w_dload), .ld_val(w_dval.st),
    .borrow_in(w_b[1]), .q(w_q.st), .borrow_out(w_b[2]));
  bcd_down_digit #(.MAX(UNITS_MAX), .W(UNITS_W)) u_mu (
    .clk(clk), .reset(reset), .load(w_dload), .ld_val(w_dval.mu),
    .borrow_in(w_b[2]), .q(w_q.mu), .borrow_out(w_b[3]));
  bcd_down_digit #(.MAX(TENS_MAX), .W(TENS_W)) u_mt (
    .clk(clk), .reset(reset), .load(w_dload), .ld_val(w_dval.mt),
    .borrow_in(w_b[3]), .q(w_q.mt), .borrow_out(w_b[4]));

  always_comb begin
    w_nxt      = r_state;
    w_reload   = 1'b0;
    w_done_nxt = 1'b0;
    if (load) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (start && w_nz) w_nxt = S_RUN;
        S_RUN: begin
          if (pause) begin
            w_nxt = S_PAUSED;
          end else if (w_dec && (w_term || w_b[4])) begin
            w_done_nxt = w_term;
            // A 00:00 preset cannot be reloaded meaningfully: expire instead.
            if (AUTO_RELOAD && w_term && (r_rld != '0)) w_reload = 1'b1;
            else                                        w_nxt    = S_EXPIRED;
          end
        end
        S_PAUSED:  if (start && !pause) w_nxt = S_RUN;
        S_EXPIRED: w_nxt = S_EXPIRED;
        default:   w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_rld     <= '0;
    end else begin
      r_state   <= w_nxt;
      r_running <= (w_nxt == S_RUN);
      r_done    <= w_done_nxt;
      if (load) r_rld <= w_clamp;
    end
  end

  assign min_tens  = w_q.mt;
  assign min_units = w_q.mu;
  assign sec_tens  = w_q.st;
  assign sec_units = w_q.su;
  assign running   = r_running;
  assign done      = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, tick, load, start, pause;
  logic [2:0] ld_mt, ld_st;
  logic [3:0] ld_mu, ld_su;

  logic [2:0] mt0, st0, mt1, st1;
  logic [3:0] mu0, su0, mu1, su1;
  logic       run0, done0, run1, done1;
  logic [15:0] t0, t1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .ld_min_tens(ld_mt), .ld_min_units(ld_mu), .ld_sec_tens(ld_st), .ld_sec_units(ld_su),
    .start(start), .pause(pause),
    .min_tens(mt0), .min_units(mu0), .sec_tens(st0), .sec_units(su0),
    .running(run0), .done(done0));

  countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .ld_min_tens(ld_mt), .ld_min_units(ld_mu), .ld_sec_tens(ld_st), .ld_sec_units(ld_su),
    .start(start), .pause(pause),
    .min_tens(mt1), .min_units(mu1), .sec_tens(st1), .sec_units(su1),
    .running(run1), .done(done1));

  // mm:ss displayed as four hex nibbles, e.g. 16'h5959 = 59:59
  assign t0 = {1'b0, mt0, mu0, 1'b0, st0, su0};
  assign t1 = {1'b0, mt1, mu1, 1'b0, st1, su1};

  typedef struct {
    logic       ld;
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
    logic       start, pause, tick;
    logic [15:0] e_t;
    logic       e_run, e_done;
  } vec_t;

  vec_t tv[21];

  function automatic vec_t mk(input logic ld, input logic [2:0] mt, input logic [3:0] mu,
                              input logic [2:0] st, input logic [3:0] su,
                              input logic s, input logic p, input logic tk,
                              input logic [15:0] et, input logic er, input logic ed);
    vec_t v;
    v.ld = ld; v.mt = mt; v.mu = mu; v.st = st; v.su = su;
    v.start = s; v.pause = p; v.tick = tk;
    v.e_t = et; v.e_run = er; v.e_done = ed;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, sc;
    m = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic ld, input logic [2:0] mt, input logic [3:0] mu,
                       input logic [2:0] st, input logic [3:0] su,
                       input logic s, input logic p, input logic tk);
    load = ld; ld_mt = mt; ld_mu = mu; ld_st = st; ld_su = su;
    start = s; pause = p; tick = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_time", t0, 16'h0000);
    chk("reset_running", run0, 0);
    chk("reset_done", done0, 0);
    step();
    reset = 1'b1;

    tv[0]  = mk(1, 7, 12, 6, 15, 0, 0, 0, 16'h5959, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h5959, 1, 0);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h5958, 1, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h5958, 0, 0);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h5958, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h5958, 1, 0);
    tv[6]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0);
    tv[8]  = mk(1, 1, 2, 3, 9, 1, 0, 0, 16'h1239, 0, 0);
    tv[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h1239, 1, 0);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h1238, 1, 0);
    tv[11] = mk(1, 0, 1, 0, 0, 0, 0, 0, 16'h0100, 0, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0100, 1, 0);
    tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0059, 1, 0);
    tv[14] = mk(1, 0, 0, 0, 1, 0, 0, 0, 16'h0001, 0, 0);
    tv[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h0001, 1, 0);
    tv[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 1);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    tv[18] = mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0);
    tv[19] = mk(1, 0, 0, 0, 2, 0, 0, 0, 16'h0002, 0, 0);
    tv[20] = mk(1, 3, 10, 7, 4, 0, 0, 0, 16'h3954, 0, 0);

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].ld, tv[i].mt, tv[i].mu, tv[i].st, tv[i].su,
            tv[i].start, tv[i].pause, tv[i].tick);
      step();
      chk($sformatf("vec%0d_time", i), t0, tv[i].e_t);
      chk($sformatf("vec%0d_running", i), run0, tv[i].e_run);
      chk($sformatf("vec%0d_done", i), done0, tv[i].e_done);
    end

    // 01:05 full countdown to expiry
    drive(1, 0, 1, 0, 5, 0, 0, 0); step();
    chk("cd_load", t0, 16'h0105);
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    chk("cd_start_running", run0, 1);
    for (int i = 1; i <= 65; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1); step();
      chk($sformatf("cd_tick%0d_time", i), t0, to_bcd(65 - i));
      chk($sformatf("cd_tick%0d_done", i), done0, (i == 65));
      chk($sformatf("cd_tick%0d_running", i), run0, (i < 65));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("cd_after_done", done0, 0);
    chk("cd_after_running", run0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1); step();
    chk("cd_expired_start_time", t0, 16'h0000);
    chk("cd_expired_start_running", run0, 0);

    // pause / resume
    drive(1, 0, 0, 0, 3, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("pz_first_tick", t0, 16'h0002);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    chk("pz_paused_running", run0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1); step();
      chk($sformatf("pz_hold%0d", i), t0, 16'h0002);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    chk("pz_resume_running", run0, 1);
    chk("pz_resume_time", t0, 16'h0002);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("pz_t1", t0, 16'h0001);
    step();
    chk("pz_t0", t0, 16'h0000);
    chk("pz_done", done0, 1);

    // auto-reload instance
    drive(1, 0, 0, 0, 2, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1); step();
      chk($sformatf("ar%0d_time", i), t1, (i % 2 == 0) ? 16'h0001 : 16'h0002);
      chk($sformatf("ar%0d_done", i), done1, (i % 2 == 1));
      chk($sformatf("ar%0d_running", i), run1, 1);
    end

    // async reset mid-run
    drive(1, 0, 0, 3, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("rst_pre_time", t0, 16'h0030);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_time", t0, 16'h0000);
    chk("rst_async_running", run0, 0);
    chk("rst_async_time_ar", t1, 16'h0000);
    #2 reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 1); step();
    chk("rst_start_time", t0, 16'h0000);
    chk("rst_start_running", run0, 0);
    chk("rst_start_running_ar", run1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter AUTO_RELOAD, default 0; when 1, timer reloads the last loaded value at terminal count and keeps running.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tick  input  1  count-enable strobe; one decrement per clk with tick=1 while RUN.
REQ-005 load  input  1  load request; captures ld_* digits.
REQ-006 ld_min_tens, ld_sec_tens  input  3 each; ld_min_units, ld_sec_units  input  4 each  BCD preset value mm:ss.
REQ-007 start  input  1  begin or resume counting.
REQ-008 pause  input  1  hold count.
REQ-009 min_tens, sec_tens  output  3 each; min_units, sec_units  output  4 each  current BCD value.
REQ-010 running  output  1  high in RUN state.
REQ-011 done  output  1  one-clk pulse on reaching 00:00.

Function
REQ-012 FSM states IDLE, RUN, PAUSED, EXPIRED.
- IDLE: start with nonzero count -> RUN; start at 00:00 -> stay IDLE.
- RUN: pause -> PAUSED; terminal decrement -> EXPIRED (AUTO_RELOAD=0) or RUN with reload (AUTO_RELOAD=1).
- PAUSED: start -> RUN.
- EXPIRED: start -> stays EXPIRED until load; load -> IDLE.
REQ-013 load has top priority in every state: next clk count = clamped ld_* value, state -> IDLE, done=0.
REQ-014 Clamp on load: units digit >9 -> 9; tens digit >5 -> 5 (per digit, independently).
REQ-015 Decrement in RUN when tick=1: sec_units borrows 0->9; sec_tens borrows 0->5 when sec_units borrows; min_units 0->9 on sec_tens borrow; min_tens 0->5 on min_units borrow; no digit exceeds its max.
REQ-016 Terminal decrement = count 00:01 with tick=1; next clk count=00:00 and done=1 for exactly that one clk.
REQ-017 AUTO_RELOAD=1: instead of 00:00, next clk count = last loaded value, done=1 one clk, state remains RUN; if last loaded value is 00:00, go to EXPIRED.
REQ-018 Simultaneous start and pause in RUN or PAUSED: pause wins.
REQ-019 tick ignored in IDLE, PAUSED, EXPIRED; count holds.
REQ-020 Latency: state and count change on the clk edge where the input is sampled; outputs registered, no combinational input-to-output path.
REQ-021 running = (state==RUN), registered with state.

Reset
REQ-022 reset low asynchronously forces count 00:00, stored reload value 00:00, state IDLE, running=0, done=0.
REQ-023 reset deassertion mid-count: no residue; first post-reset edge behaves as from IDLE at 00:00.

Structure
REQ-024 Shared package timer_pkg holds state enum type, constants UNITS_MAX=9, TENS_MAX=5, digit widths 4 and 3.
REQ-025 One sub-module bcd_down_digit (parameter MAX, width): inputs clk, reset, load, ld_val, borrow_in; outputs q, borrow_out (= borrow_in & q==0); four instances chained.
REQ-026 FSM, clamp, reload register and done generation live in countdown_timer.

Verification
REQ-027 load 01:05, start, tick every clk -> 01:04,01:03,...,01:00,00:59 after 6 ticks; 00:00 with done=1 after 65 ticks; then EXPIRED, running=0.
REQ-028 Load 00:03, start, tick, pause after 1 tick, tick 10 clk, start -> holds 00:02 while PAUSED, resumes 00:01, 00:00.
REQ-029 Load digits 7,12,6,15 (mt,mu,st,su) -> count reads 59:59.
REQ-030 AUTO_RELOAD=1, load 00:02, start, continuous tick -> 00:01, 00:02 (done=1), 00:01, 00:02 (done=1), running stays 1.
REQ-031 Assert reset low mid-run at 00:30 asynchronously between edges -> outputs 00:00, running=0 immediately; start with no load -> stays IDLE.
REQ-032 start and pause same clk in RUN -> PAUSED; load and start same clk -> IDLE with loaded value.
